// File: rtl/spi_ram.sv
// spi_ram: command-driven single-port byte RAM behind the SPI slave.
// Decodes 10-bit rx words into address loads, writes and reads.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  typedef enum logic [1:0] {
    OP_WADDR = 2'b00,
    OP_WDATA = 2'b01,
    OP_RADDR = 2'b10,
    OP_RDATA = 2'b11
  } op_e;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] din_addr;
  op_e                  op;
  logic                 acc;
  logic                 inc;

  assign op       = op_e'(din[9:8]);
  assign din_addr = din[ADDR_SIZE-1:0];
  assign acc      = rx_valid && !rst;
  assign inc      = (AUTO_INC != 0);

  // array carries no reset so it maps onto a plain RAM macro
  always_ff @(posedge clk) begin
    if (acc && op == OP_WDATA)
      mem[wr_addr] <= din[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else if (rx_valid) begin
      unique case (op)
        OP_WADDR: begin
          wr_addr  <= din_addr;
          tx_valid <= 1'b0;
        end
        OP_WDATA: begin
          if (inc)
            wr_addr <= wr_addr + ADDR_SIZE'(1);
          tx_valid <= 1'b0;
        end
        OP_RADDR: begin
          rd_addr  <= din_addr;
          tx_valid <= 1'b0;
        end
        OP_RDATA: begin
          dout     <= mem[rd_addr];
          tx_valid <= 1'b1;
          if (inc)
            rd_addr <= rd_addr + ADDR_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_ram.md
Name: spi_ram

Overview:
Single-port byte RAM that sits directly downstream of the SPI slave and consumes its 10-bit receive words. Each word is decoded as a command: load write address, write data, load read address, or read data. For a read-data command, the addressed byte is returned on dout/tx_valid, which the SPI slave shifts out on MISO. This block is the memory stage instantiated beside the SPI slave inside the SPI wrapper.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE
ADDR_SIZE, 8, address width; address taken from din[ADDR_SIZE-1:0]
AUTO_INC, 0, 1 = write address post-increments after each write-data command and read address post-increments after each read-data command (modulo MEM_DEPTH)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  10  command word from SPI slave; din[9:8] = opcode, din[7:0] = payload
rx_valid  input  1  din valid this cycle; one command accepted per cycle when high
dout  output  8  read data to SPI slave
tx_valid  output  1  dout holds a valid read result

Behaviour:
- Reset (rst=1 at clk edge): wr_addr=0, rd_addr=0, dout=8'h00, tx_valid=0. Memory contents are not cleared and persist across reset. Reset overrides any same-cycle rx_valid.
- Command decode, only when rx_valid=1 at the clk edge; rx_valid=0 means no state change:
  - 2'b00: wr_addr <= din[ADDR_SIZE-1:0]
  - 2'b01: mem[wr_addr] <= din[7:0]; if AUTO_INC, wr_addr <= wr_addr+1 (wraps MEM_DEPTH-1 -> 0)
  - 2'b10: rd_addr <= din[ADDR_SIZE-1:0]
  - 2'b11: dout <= mem[rd_addr]; tx_valid <= 1; if AUTO_INC, rd_addr <= rd_addr+1 (wraps). din[7:0] is ignored.
- Latency: dout/tx_valid are valid on the edge following the accepting edge of a 2'b11 command, i.e. 1 cycle.
- tx_valid hold: tx_valid stays 1 and dout stays stable until the next accepted command with opcode other than 2'b11, which clears tx_valid on that edge. dout keeps its last value and is not zeroed.
- Back-to-back 2'b11: tx_valid stays 1 and dout updates to the new byte each cycle.
- Single port: at most one memory access per cycle by construction, so there is no read/write collision.
- A read-data command with no prior read-address load uses rd_addr=0.
- Writing to the address that was just read does not alter dout until the next 2'b11 command.
- Memory is synthesizable as an inferred single-port array with no reset on the array.

Test Plan:
- Reset, then rx_valid=1 with din=10'h005, 10'h1A5, 10'h205, 10'h300 on 4 consecutive cycles -> one cycle after the 4th, dout=8'hA5, tx_valid=1.
- After the above, din=10'h000 with rx_valid=1 -> tx_valid=0 next cycle; dout still 8'hA5.
- rx_valid=0 with din=10'h1FF held for 5 cycles -> memory and addresses unchanged; a following read of addr 0x05 still returns 8'hA5.
- AUTO_INC=1: din=10'h0FF, 10'h111, 10'h122, then 10'h2FF, 10'h300, 10'h300 -> dout=8'h11 then 8'h22 on consecutive cycles (wrap FF->00), tx_valid=1 throughout.
- Write 8'h3C to addr 0x10, assert rst for 1 cycle, then din=10'h210, 10'h300 -> dout=8'h3C (memory survives reset). During the rst cycle: dout=8'h00 and tx_valid=0.
- rst=1 in the same cycle as rx_valid=1, din=10'h300 -> tx_valid=0 and dout=8'h00 afterwards (reset wins).
